// File: rtl/gray_burst_ctrl.sv
// Burst sequencer that streams consecutive Gray codes of a binary count
// over a valid/ready interface, with abort and one-cycle completion pulse.
module gray_burst_ctrl #(
    parameter int N     = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [N-1:0]     cmd_start,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_dir,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     gray_code,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [N-1:0]     BIN_ONE = N'(1);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [N-1:0]     bin_cnt;
    logic [N-1:0]     bin_nxt;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] rem_nxt;
    logic             dir;
    logic             dir_nxt;
    logic             is_last;

    // Next-state, datapath update and registered-state decoded outputs.
    always_comb begin
        state_nxt = state;
        bin_nxt   = bin_cnt;
        rem_nxt   = remaining;
        dir_nxt   = dir;
        cmd_ready = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE);
        is_last   = (remaining == '0);
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = RUN;
                    bin_nxt   = cmd_start;
                    rem_nxt   = cmd_len;
                    dir_nxt   = cmd_dir;
                end
            end
            RUN: begin
                out_valid = 1'b1;
                out_last  = is_last;
                if (out_ready && is_last) begin
                    // Completion wins over a coincident abort.
                    state_nxt = DONE;
                end else begin
                    if (out_ready) begin
                        bin_nxt = dir ? bin_cnt - BIN_ONE
                                      : bin_cnt + BIN_ONE;
                        rem_nxt = remaining - LEN_ONE;
                    end
                    if (abort) begin
                        state_nxt = IDLE;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Gray code is formed from the count register, forced to zero when idle.
    assign gray_code = out_valid ? (bin_cnt ^ (bin_cnt >> 1)) : '0;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bin_cnt   <= '0;
            remaining <= '0;
            dir       <= 1'b0;
        end else begin
            state     <= state_nxt;
            bin_cnt   <= bin_nxt;
            remaining <= rem_nxt;
            dir       <= dir_nxt;
        end
    end

endmodule
